mdu_iter: RTL

Parametrised iterative multiply/divide unit, successor to the single-cycle-compute MDU in the EX stage. Multiply is radix-2 shift-add; divide is restoring on magnitudes. Both take a fixed, documented number of cycles. HI/LO are written only when an operation completes. A `cancel` input lets the exception logic abort a multiply or divide that is already in flight.

---
 rtl/mdu_iter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply, restoring divide on magnitudes.
// Define MDU_MADD_EN to decode madd/maddu/msub/msubu (accumulate into {HI,LO}).
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [3:0]       op,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_MULTU = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]   a_q, a_d;       // divisor / multiplicand magnitude
  logic [WIDTH-1:0]   b_q, b_d;       // dividend->quotient / multiplier magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;   // product, or remainder in the low half
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               cmd_go, cmd_mul, cmd_sgn;
  logic [WIDTH-1:0]   mag_a, mag_b, mul_add;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               neg_res;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  always_comb begin
    cmd_go  = 1'b0;
    cmd_mul = 1'b0;
    cmd_sgn = 1'b0;
    case (op)
      OP_MULT:  begin cmd_go = 1'b1; cmd_mul = 1'b1; cmd_sgn = 1'b1; end
      OP_DIV:   begin cmd_go = 1'b1; cmd_sgn = 1'b1; end
      OP_MULTU: begin cmd_go = 1'b1; cmd_mul = 1'b1; end
      OP_DIVU:  begin cmd_go = 1'b1; end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MSUB:   begin cmd_go = 1'b1; cmd_mul = 1'b1; cmd_sgn = 1'b1; end
      OP_MADDU, OP_MSUBU: begin cmd_go = 1'b1; cmd_mul = 1'b1; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    mag_a     = (cmd_sgn && D1[WIDTH-1]) ? -D1 : D1;
    mag_b     = (cmd_sgn && D2[WIDTH-1]) ? -D2 : D2;
    mul_add   = b_q[0] ? a_q : {WIDTH{1'b0}};
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
    div_shift = {acc_q[WIDTH-1:0], b_q[WIDTH-1]};
    // Two guard bits so a zero divisor never reads as a borrow; this makes divide-by-zero
    // fall out as quotient all-ones and remainder equal to the dividend.
    div_diff  = {1'b0, div_shift} - {2'b00, a_q};
    neg_res   = sa_q ^ sb_q;
    prod_s    = neg_res ? -acc_q : acc_q;
    quo_s     = neg_res ? -b_q : b_q;
    rem_s     = sa_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

    if (cancel) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_go) begin
            op_d    = op;
            sa_d    = cmd_sgn & D1[WIDTH-1];
            sb_d    = cmd_sgn & D2[WIDTH-1];
            a_d     = mag_b;
            b_d     = mag_a;
            acc_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
            state_d = cmd_mul ? S_MUL : S_DIV;
          end else if (op == OP_MTHI) begin
            hi_d = D1;
          end else if (op == OP_MTLO) begin
            lo_d = D1;
          end
        end
        S_MUL: begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          b_d   = b_q >> 1;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
        S_DIV: begin
          acc_d = {acc_q[2*WIDTH-1:WIDTH],
                   div_diff[WIDTH+1] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]};
          b_d   = {b_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
        S_FIX: begin
          case (op_q)
            OP_MULT, OP_MULTU: {hi_d, lo_d} = prod_s;
            OP_DIV, OP_DIVU: begin
              hi_d = rem_s;
              lo_d = quo_s;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
            OP_MSUB, OP_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
`endif
            default: ;
          endcase
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Datapath registers carry no reset; they are only observed after a full iteration.
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    sa_q  <= sa_d;
    sb_q  <= sb_d;
    a_q   <= a_d;
    b_q   <= b_d;
    acc_q <= acc_d;
  end

  assign busy = (state_q != S_IDLE);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
